// File: rtl/psum_accum.sv
// Per-lane saturating partial-sum accumulator feeding the quantizer.
// Each lane sums NUM_PASS valid beats (or fewer on flush) and emits a registered, one-cycle-valid result.
module psum_accum #(
    parameter int LANES    = 4,
    parameter int IN_W     = 16,
    parameter int ACC_W    = 24,
    parameter int NUM_PASS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       dv_psum,
    input  logic [LANES*IN_W-1:0]  psum,
    input  logic                   flush,
    output logic [LANES-1:0]       dv_acc,
    output logic [LANES*ACC_W-1:0] acc_out,
    output logic [LANES-1:0]       sat,
    output logic [LANES-1:0]       busy
);

    localparam int               CNT_W    = $clog2(NUM_PASS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PASS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e           state_q [LANES];
    state_e           state_d [LANES];
    logic [ACC_W-1:0] acc_q   [LANES];
    logic [ACC_W-1:0] acc_d   [LANES];
    logic [ACC_W-1:0] out_q   [LANES];
    logic [ACC_W-1:0] out_d   [LANES];
    logic [CNT_W-1:0] cnt_q   [LANES];
    logic [CNT_W-1:0] cnt_d   [LANES];
    logic [ACC_W:0]   ext     [LANES];
    logic [ACC_W:0]   sum_w   [LANES];
    logic [ACC_W-1:0] sum     [LANES];
    logic [LANES-1:0] clamp;
    logic [LANES-1:0] sticky_q, sticky_d;
    logic [LANES-1:0] sat_q, sat_d;
    logic [LANES-1:0] dv_q, dv_d;

    // One guard bit above ACC_W exposes overflow: sign and guard disagree exactly when the result does not fit.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign ext[i]   = {{(ACC_W+1-IN_W){psum[i*IN_W+IN_W-1]}}, psum[i*IN_W +: IN_W]};
        assign sum_w[i] = ((state_q[i] == ACCUM) ? {acc_q[i][ACC_W-1], acc_q[i]} : '0) + ext[i];
        assign clamp[i] = sum_w[i][ACC_W] ^ sum_w[i][ACC_W-1];
        assign sum[i]   = !clamp[i] ? sum_w[i][ACC_W-1:0]
                        : (sum_w[i][ACC_W] ? ACC_MIN : ACC_MAX);
        assign acc_out[i*ACC_W +: ACC_W] = out_q[i];
        assign busy[i]  = (state_q[i] == ACCUM);
    end

    assign dv_acc = dv_q;
    assign sat    = sat_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        for (int i = 0; i < LANES; i++) begin
            state_d[i]  = state_q[i];
            acc_d[i]    = acc_q[i];
            cnt_d[i]    = cnt_q[i];
            out_d[i]    = out_q[i];
            sticky_d[i] = sticky_q[i];
            sat_d[i]    = sat_q[i];
            dv_d[i]     = 1'b0;

            if (dv_psum[i]) begin
                if (cnt_q[i] == LAST_CNT || flush) begin
                    out_d[i]    = sum[i];
                    sat_d[i]    = sticky_q[i] | clamp[i];
                    dv_d[i]     = 1'b1;
                    acc_d[i]    = '0;
                    cnt_d[i]    = '0;
                    sticky_d[i] = 1'b0;
                    state_d[i]  = IDLE;
                end else begin
                    acc_d[i]    = sum[i];
                    cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                    sticky_d[i] = sticky_q[i] | clamp[i];
                    state_d[i]  = ACCUM;
                end
            end else if (flush && state_q[i] == ACCUM) begin
                out_d[i]    = acc_q[i];
                sat_d[i]    = sticky_q[i];
                dv_d[i]     = 1'b1;
                acc_d[i]    = '0;
                cnt_d[i]    = '0;
                sticky_d[i] = 1'b0;
                state_d[i]  = IDLE;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every lane sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= IDLE;
                acc_q[i]   <= '0;
                cnt_q[i]   <= '0;
                out_q[i]   <= '0;
            end
            sticky_q <= '0;
            sat_q    <= '0;
            dv_q     <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                acc_q[i]   <= acc_d[i];
                cnt_q[i]   <= cnt_d[i];
                out_q[i]   <= out_d[i];
            end
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
            dv_q     <= dv_d;
        end
    end

endmodule
